// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared encodings for the multicycle RISC-V control path: FSM state codes,
// opcode constants, ALU operation codes, mux-select encodings, and a helper
// that resolves a conditional branch from funct3 and the ALU flags.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ITYPEEX = 4'd7,
    S_JEX     = 4'd8,
    S_ALUWB   = 4'd9,
    S_BEQX    = 4'd10,
    S_JALREX  = 4'd11,
    S_LINKEX  = 4'd12,
    S_UTYPEEX = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Returns {legal, taken} for a branch with the given funct3.
  function automatic logic [1:0] branch_eval(input logic [2:0] f3,
                                             input logic       eq,
                                             input logic       lt);
    case (f3)
      3'b000:  return {1'b1, eq};
      3'b001:  return {1'b1, ~eq};
      3'b100:  return {1'b1, lt};
      3'b101:  return {1'b1, ~lt};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_alu_decoder.sv
// rv_alu_decoder
// Combinational ALU operation select for the multicycle controller.
// Ports:
//   state_i    - current controller state
//   opcode_i   - instruction opcode (distinguishes LUI from AUIPC)
//   funct3_i   - instruction funct3
//   funct7b5_i - instruction bit 30 (SUB vs ADD for register ops)
//   alu_ctrl_o - ALU operation code
module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output logic [3:0]  alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (state_i)
      S_RTYPEEX, S_ITYPEEX: begin
        case (funct3_i)
          // Immediate ops have no subtract form; bit 30 is part of the immediate.
          3'b000:  alu_ctrl_o = (state_i == S_RTYPEEX && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      S_BEQX:    alu_ctrl_o = ALU_SUB;
      S_UTYPEEX: alu_ctrl_o = (opcode_i == OP_LUI) ? ALU_PASSB : ALU_ADD;
      default:   alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
// Control FSM for the multicycle RISC-V datapath. Sequences fetch, decode,
// execute, memory and writeback, drives all mux selects and write strobes,
// and stalls on mem_ready in FETCH, MEMRD and MEMWR.
// Ports:
//   clk, reset_n                   - clock, async active-low reset
//   opcode, funct3, funct7b5       - instruction fields from IR
//   alu_eq, alu_lt                 - ALU compare flags for branches
//   mem_ready                      - memory completed this cycle's access
//   pc_write, ir_write, mem_read,
//   mem_write, reg_write           - strobes (forced 0 during reset)
//   adr_src, alu_src_a, alu_src_b,
//   alu_ctrl, result_src           - datapath selects
//   illegal                        - one-cycle pulse on undecodable instr
//   state                          - current state (debug)
//   retired                        - retired-instruction count, present only
//                                    when CTRL_RETIRE_CNT_EN is defined
//
// state     | meaning
// FETCH   0 | read instruction at PC, PC += 4
// DECODE  1 | compute branch/JAL target, dispatch on opcode
// MEMADR  2 | compute load/store address
// MEMRD   3 | load read, wait for mem_ready
// MEMWB   4 | write load data to rd
// MEMWR   5 | store write, wait for mem_ready
// RTYPEEX 6 | register-register ALU op
// ITYPEEX 7 | register-immediate ALU op
// JEX     8 | JAL: PC <= target, compute link
// ALUWB   9 | write ALUOut to rd
// BEQX   10 | conditional branch resolve
// JALREX 11 | JALR: PC <= rs1 + imm
// LINKEX 12 | JALR: compute link
// UTYPEEX13 | LUI / AUIPC
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        alu_eq,
  input  logic        alu_lt,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  result_src,
  output logic        illegal,
  output logic [3:0]  state
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  state_e     state_q, state_d;
  logic       pc_write_c, ir_write_c, adr_src_c, mem_read_c, mem_write_c;
  logic       reg_write_c, illegal_c;
  logic [1:0] src_a_c, src_b_c, result_c;
  logic [3:0] alu_ctrl_c;
  logic [1:0] br;

  rv_alu_decoder u_alu_dec (
    .state_i    (state_q),
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (alu_ctrl_c)
  );

  assign br = branch_eval(funct3, alu_eq, alu_lt);

  always_comb begin
    state_d     = S_FETCH;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    adr_src_c   = ADR_PC;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    src_a_c     = SRCA_PC;
    src_b_c     = SRCB_RS2;
    result_c    = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        adr_src_c  = ADR_PC;
        src_a_c    = SRCA_PC;
        src_b_c    = SRCB_FOUR;
        result_c   = RES_ALU;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:            state_d = S_RTYPEEX;
          OP_IMM:            state_d = S_ITYPEEX;
          OP_JAL:            state_d = S_JEX;
          OP_JALR:           state_d = S_JALREX;
          OP_BRANCH:         state_d = S_BEQX;
          OP_LUI, OP_AUIPC:  state_d = S_UTYPEEX;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        adr_src_c  = ADR_ALUOUT;
        state_d    = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_c    = RES_MEM;
        reg_write_c = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        adr_src_c   = ADR_ALUOUT;
        state_d     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_RS2;
        state_d = S_ALUWB;
      end
      S_ITYPEEX: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_JEX: begin
        // Target was latched into ALUOut during DECODE; ALU now forms PC+4 link.
        pc_write_c = 1'b1;
        result_c   = RES_ALUOUT;
        src_a_c    = SRCA_OLDPC;
        src_b_c    = SRCB_FOUR;
        state_d    = S_ALUWB;
      end
      S_JALREX: begin
        // Raw ALU result goes straight to PC so the link can be computed next.
        src_a_c    = SRCA_RS1;
        src_b_c    = SRCB_IMM;
        result_c   = RES_ALU;
        pc_write_c = 1'b1;
        state_d    = S_LINKEX;
      end
      S_LINKEX: begin
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_FOUR;
        state_d = S_ALUWB;
      end
      S_UTYPEEX: begin
        src_a_c = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        result_c    = RES_ALUOUT;
        reg_write_c = 1'b1;
      end
      S_BEQX: begin
        src_a_c    = SRCA_RS1;
        src_b_c    = SRCB_RS2;
        result_c   = RES_ALUOUT;
        pc_write_c = br[1] & br[0];
        illegal_c  = ~br[1];
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Strobes must be quiet the instant reset asserts, even mid-access.
  assign pc_write   = reset_n & pc_write_c;
  assign ir_write   = reset_n & ir_write_c;
  assign mem_read   = reset_n & mem_read_c;
  assign mem_write  = reset_n & mem_write_c;
  assign reg_write  = reset_n & reg_write_c;
  assign illegal    = reset_n & illegal_c;
  assign adr_src    = reset_n & adr_src_c;
  assign alu_src_a  = reset_n ? src_a_c : 2'd0;
  assign alu_src_b  = reset_n ? src_b_c : 2'd0;
  assign result_src = reset_n ? result_c : 2'd0;
  assign alu_ctrl   = reset_n ? alu_ctrl_c : ALU_ADD;
  assign state      = state_q;

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // Holding in FETCH is not a transition; illegal exits do not retire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      retired_q <= 32'd0;
    else if (state_d == S_FETCH && state_q != S_FETCH && !illegal_c)
      retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5, alu_eq, alu_lt, mem_ready;
  logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_ctrl, state;
`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  rv_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .alu_eq(alu_eq), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .result_src(result_src), .illegal(illegal), .state(state)
`ifdef CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, mrd, mwr, rw;
    logic [1:0] a, b;
    logic [3:0] alu;
    logic [1:0] rs;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_ret = 0;

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, irw, adr, mrd, mwr, rw,
                              input logic [1:0] a, b, input logic [3:0] alu,
                              input logic [1:0] rs, input logic ill);
    return '{st, pcw, irw, adr, mrd, mwr, rw, a, b, alu, rs, ill};
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, act;
      e   = q.pop_front();
      act = '{state, pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
              alu_src_a, alu_src_b, alu_ctrl, result_src, illegal};
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t state=%0d: actual=%h required=%h", $time, e.st, act, e);
      end
    end
  end

  task automatic ins(input logic [31:0] w);
    opcode = w[6:0]; funct3 = w[14:12]; funct7b5 = w[30];
  endtask

  task automatic step(input exp_t e, input logic mr);
    mem_ready = mr;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic mr);
    step(mk(4'd0, mr, mr, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 4'd0, 2'd2, 1'b0), mr);
  endtask
  task automatic decode();
    step(mk(4'd1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 2'd0, 1'b0), 1'b1);
  endtask
  task automatic aluwb();
    step(mk(4'd9, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0, 2'd0, 1'b0), 1'b1);
  endtask

  task automatic done(input bit counts);
    if (counts) exp_ret++;
`ifdef CTRL_RETIRE_CNT_EN
    n_chk++;
    if (retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL retired: actual=%0d required=%0d", retired, exp_ret);
    end
`endif
  endtask

  task automatic branch(input logic [31:0] w, input logic eq, lt, input logic pcw, ill);
    ins(w); alu_eq = eq; alu_lt = lt;
    fetch(1); decode();
    step(mk(4'd10, pcw, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd1, 2'd0, ill), 1'b1);
    done(!ill);
  endtask

  localparam exp_t ZERO = '0;

  initial begin
    reset_n = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    alu_eq = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(ZERO, 1'b0);
    step(ZERO, 1'b0);
    reset_n = 1'b1;

    // add x3,x1,x2
    ins(32'h002081B3); fetch(1); decode();
    step(mk(4'd6, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd0, 2'd0, 0), 1); aluwb(); done(1);
    // sub
    ins(32'h40208133); fetch(1); decode();
    step(mk(4'd6, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd1, 2'd0, 0), 1); aluwb(); done(1);
    // srli
    ins(32'h0020D093); fetch(1); decode();
    step(mk(4'd7, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd6, 2'd0, 0), 1); aluwb(); done(1);
    // addi with bit30 set stays ADD
    ins(32'h40008093); fetch(1); decode();
    step(mk(4'd7, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 2'd0, 0), 1); aluwb(); done(1);
    // lw, two stall cycles in MEMRD: 7 cycles total
    ins(32'h0000A083); fetch(1); decode();
    step(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 2'd0, 0), 1);
    step(mk(4'd3, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0), 0);
    step(mk(4'd3, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0), 0);
    step(mk(4'd3, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0), 1);
    step(mk(4'd4, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0, 2'd1, 0), 1); done(1);
    // sw with one fetch stall and one write stall
    ins(32'h0020A023); fetch(0); fetch(1); decode();
    step(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 2'd0, 0), 1);
    step(mk(4'd5, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0), 0);
    step(mk(4'd5, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0), 1); done(1);
    // branches
    branch(32'h00209463, 1'b1, 1'b0, 1'b0, 1'b0);  // bne, equal -> not taken
    branch(32'h00209463, 1'b0, 1'b0, 1'b1, 1'b0);  // bne, not equal -> taken
    branch(32'h0020D463, 1'b0, 1'b0, 1'b1, 1'b0);  // bge, !lt -> taken
    branch(32'h0020C463, 1'b0, 1'b1, 1'b1, 1'b0);  // blt, lt -> taken
    branch(32'h00208463, 1'b0, 1'b0, 1'b0, 1'b0);  // beq, !eq -> not taken
    branch(32'h0020A463, 1'b1, 1'b1, 1'b0, 1'b1);  // funct3 010 -> illegal
    // jal
    ins(32'h008000EF); fetch(1); decode();
    step(mk(4'd8, 1, 0, 0, 0, 0, 0, 2'd1, 2'd2, 4'd0, 2'd0, 0), 1); aluwb(); done(1);
    // jalr
    ins(32'h000080E7); fetch(1); decode();
    step(mk(4'd11, 1, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 2'd2, 0), 1);
    step(mk(4'd12, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 4'd0, 2'd0, 0), 1); aluwb(); done(1);
    // lui, auipc
    ins(32'h123450B7); fetch(1); decode();
    step(mk(4'd13, 0, 0, 0, 0, 0, 0, 2'd3, 2'd1, 4'd8, 2'd0, 0), 1); aluwb(); done(1);
    ins(32'h00000097); fetch(1); decode();
    step(mk(4'd13, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 2'd0, 0), 1); aluwb(); done(1);
    // illegal opcode
    ins(32'h0000007F); fetch(1);
    step(mk(4'd1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 2'd0, 1), 1); done(0);
    fetch(0);

    // reset asserted while a store is waiting
    ins(32'h0020A023); fetch(1); decode();
    step(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 2'd0, 0), 1);
    mem_ready = 1'b0;
    q.push_back(mk(4'd5, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0));
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_store: actual mem_write=%b state=%0d required mem_write=0 state=0",
               mem_write, state);
    end
    @(posedge clk); #1;
    step(ZERO, 1'b0);
    reset_n = 1'b1;
    exp_ret = 0;
    fetch(1); decode();
    step(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 2'd0, 0), 1);
    step(mk(4'd5, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0), 1); done(1);

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual pending=%0d required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
